// File: rtl/parity_stream_checker.sv
// Streaming per-lane word parity and frame LRC checker.
// Results are registered one cycle after each accepted beat.
module parity_stream_checker #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 2,
  parameter int ODD       = 0,
  parameter int FRAME_MAX = 8,
  parameter int CNT_W     = 8
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_par,
  input  logic                    in_last,
  input  logic                    chk_en,
  input  logic                    cnt_clr,
  output logic                    out_valid,
  output logic [LANES-1:0]        word_err,
  output logic                    frame_done,
  output logic [LANES-1:0]        frame_err,
  output logic                    len_err,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int BW = $clog2(FRAME_MAX + 1);
  localparam logic [BW-1:0] LAST_ACC = BW'(FRAME_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic ODD_B = (ODD != 0);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                  state;
  logic [LANES*DATA_W-1:0] lrc;
  logic [BW-1:0]           beat_cnt;

  logic [LANES-1:0] werr;
  logic [LANES-1:0] ferr;
  logic             hit_max;
  logic             lerr;
  logic             any_err;
  logic             closes;

  // per-beat verdicts: word parity, frame compare, length limit
  always_comb begin
    werr    = '0;
    ferr    = '0;
    hit_max = (state == ACCUM) && !in_last
              && (beat_cnt == LAST_ACC);
    lerr    = hit_max & chk_en;
    for (int k = 0; k < LANES; k++) begin
      werr[k] = (^in_data[k*DATA_W +: DATA_W])
                ^ in_par[k] ^ ODD_B;
      if (in_last) begin
        if (state == IDLE)
          ferr[k] = |in_data[k*DATA_W +: DATA_W];
        else
          ferr[k] = lrc[k*DATA_W +: DATA_W]
                    != in_data[k*DATA_W +: DATA_W];
      end
    end
    werr    = werr & {LANES{chk_en}};
    ferr    = ferr & {LANES{chk_en}};
    any_err = (|werr) | (|ferr) | lerr;
    closes  = in_last | hit_max;
  end

  // frame tracking FSM with registered result flags and counter
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      lrc        <= '0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      word_err   <= '0;
      frame_done <= 1'b0;
      frame_err  <= '0;
      len_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      out_valid  <= in_valid;
      word_err   <= in_valid ? werr : '0;
      frame_done <= in_valid & closes;
      frame_err  <= (in_valid & in_last) ? ferr : '0;
      len_err    <= in_valid & lerr;

      if (cnt_clr)
        err_cnt <= '0;
      else if (in_valid && any_err && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + 1'b1;

      if (in_valid) begin
        unique case (state)
          IDLE: begin
            if (!in_last) begin
              lrc      <= in_data;
              beat_cnt <= BW'(1);
              state    <= ACCUM;
            end
          end
          ACCUM: begin
            if (closes) begin
              lrc      <= '0;
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              lrc      <= lrc ^ in_data;
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed checks for parity_stream_checker.
// Second instance uses the odd parity convention.
module tb_parity_stream_checker;

  logic        CK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_par = '0;
  logic        in_last = 1'b0;
  logic        chk_en = 1'b1;
  logic        cnt_clr = 1'b0;

  logic       out_valid, frame_done, len_err;
  logic [1:0] word_err, frame_err;
  logic [7:0] err_cnt;

  logic       o_valid, o_done, o_len;
  logic [1:0] o_werr, o_ferr;
  logic [7:0] o_cnt;

  int total = 0;
  int bad = 0;

  parity_stream_checker #(
    .DATA_W(16), .LANES(2), .ODD(0),
    .FRAME_MAX(8), .CNT_W(8)
  ) u_dut (
    .CK(CK), .RST(RST), .in_valid(in_valid),
    .in_data(in_data), .in_par(in_par),
    .in_last(in_last), .chk_en(chk_en),
    .cnt_clr(cnt_clr), .out_valid(out_valid),
    .word_err(word_err), .frame_done(frame_done),
    .frame_err(frame_err), .len_err(len_err),
    .err_cnt(err_cnt)
  );

  parity_stream_checker #(
    .DATA_W(16), .LANES(2), .ODD(1),
    .FRAME_MAX(8), .CNT_W(8)
  ) u_odd (
    .CK(CK), .RST(RST), .in_valid(in_valid),
    .in_data(in_data), .in_par(in_par),
    .in_last(in_last), .chk_en(chk_en),
    .cnt_clr(cnt_clr), .out_valid(o_valid),
    .word_err(o_werr), .frame_done(o_done),
    .frame_err(o_ferr), .len_err(o_len),
    .err_cnt(o_cnt)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d0,
                      input logic [15:0] d1,
                      input logic [1:0]  p,
                      input logic        last);
    in_valid = 1'b1;
    in_data  = {d1, d0};
    in_par   = p;
    in_last  = last;
    @(posedge CK);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    @(posedge CK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_werr", 32'(word_err), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    RST = 1'b0;
    idle();

    beat(16'h0001, 16'h0003, 2'b01, 1'b0);
    chk("b1_valid", 32'(out_valid), 1);
    chk("b1_werr", 32'(word_err), 0);
    chk("b1_done", 32'(frame_done), 0);
    chk("b1_cnt", 32'(err_cnt), 0);
    chk("odd_werr", 32'(o_werr), 32'h3);
    idle();
    chk("idle_valid", 32'(out_valid), 0);

    beat(16'h0001, 16'h0003, 2'b11, 1'b0);
    chk("p1_werr", 32'(word_err), 32'h2);
    chk("p1_cnt", 32'(err_cnt), 1);

    beat(16'h0000, 16'h0000, 2'b00, 1'b1);
    chk("c1_done", 32'(frame_done), 1);
    chk("c1_ferr", 32'(frame_err), 0);
    chk("c1_cnt", 32'(err_cnt), 1);

    beat(16'h00F0, 16'h0000, 2'b00, 1'b0);
    beat(16'h0F00, 16'h0000, 2'b00, 1'b0);
    beat(16'h0FF0, 16'h0000, 2'b00, 1'b1);
    chk("f3_done", 32'(frame_done), 1);
    chk("f3_ferr", 32'(frame_err), 0);
    chk("f3_cnt", 32'(err_cnt), 1);

    beat(16'h00F0, 16'h0000, 2'b00, 1'b0);
    beat(16'h0F00, 16'h0000, 2'b00, 1'b0);
    beat(16'h0FF1, 16'h0000, 2'b01, 1'b1);
    chk("f3b_werr", 32'(word_err), 0);
    chk("f3b_ferr", 32'(frame_err), 32'h1);
    chk("f3b_cnt", 32'(err_cnt), 2);

    for (int i = 1; i <= 7; i++) begin
      beat(16'h0000, 16'h0000, 2'b00, 1'b0);
      chk("len_pre_done", 32'(frame_done), 0);
    end
    beat(16'h0000, 16'h0000, 2'b00, 1'b0);
    chk("len8_len", 32'(len_err), 1);
    chk("len8_done", 32'(frame_done), 1);
    chk("len8_ferr", 32'(frame_err), 0);
    chk("len8_cnt", 32'(err_cnt), 3);
    beat(16'h0003, 16'h0000, 2'b00, 1'b1);
    chk("b9_done", 32'(frame_done), 1);
    chk("b9_len", 32'(len_err), 0);
    chk("b9_ferr", 32'(frame_err), 32'h1);
    chk("b9_cnt", 32'(err_cnt), 4);

    chk_en = 1'b0;
    beat(16'h0001, 16'h0000, 2'b00, 1'b0);
    chk("off_werr", 32'(word_err), 0);
    beat(16'h0002, 16'h0000, 2'b01, 1'b1);
    chk("off_werr2", 32'(word_err), 0);
    chk("off_ferr", 32'(frame_err), 0);
    chk("off_cnt", 32'(err_cnt), 4);
    chk_en = 1'b1;
    beat(16'h0005, 16'h0000, 2'b00, 1'b0);
    beat(16'h0005, 16'h0000, 2'b00, 1'b1);
    chk("on_done", 32'(frame_done), 1);
    chk("on_ferr", 32'(frame_err), 0);
    chk("on_cnt", 32'(err_cnt), 4);

    cnt_clr = 1'b1;
    beat(16'h0001, 16'h0000, 2'b00, 1'b1);
    chk("clr_werr", 32'(word_err), 32'h1);
    chk("clr_cnt", 32'(err_cnt), 0);

    for (int i = 0; i < 255; i++)
      beat(16'h0001, 16'h0000, 2'b00, 1'b1);
    chk("sat_255", 32'(err_cnt), 255);
    beat(16'h0001, 16'h0000, 2'b00, 1'b1);
    chk("sat_hold", 32'(err_cnt), 255);

    beat(16'h0010, 16'h0000, 2'b01, 1'b0);
    chk("mid_valid", 32'(out_valid), 1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_cnt", 32'(err_cnt), 0);
    @(posedge CK);
    #1;
    RST = 1'b0;
    beat(16'h0000, 16'h0000, 2'b00, 1'b1);
    chk("post_done", 32'(frame_done), 1);
    chk("post_ferr", 32'(frame_err), 0);
    chk("post_cnt", 32'(err_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
- Registered, multi-lane successor to the combinational XOR-tree parity check. The old block checks one fixed group of bits against one parity condition in a single shot.
- This block checks each beat of a streaming bus per lane (word parity) and accumulates a column parity (LRC) across a frame. The last beat of a frame carries the check word, which the block compares against the accumulated parity.
- It sits on the input side of the datapath. It reports per-lane errors, frame-length violations and a saturating error count to the status logic.

Parameters:
- DATA_W, 16, data bits per lane (>=2)
- LANES, 2, number of independent lanes (>=1)
- ODD, 0, 0 = even parity convention, 1 = odd parity convention
- FRAME_MAX, 8, maximum beats per frame including the check beat (>=2)
- CNT_W, 8, width of the error counter

Ports:
- CK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- in_valid  input  1  beat present this cycle
- in_data  input  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
- in_par  input  LANES  per-lane parity bit for this beat
- in_last  input  1  this beat is the frame check beat
- chk_en  input  1  check enable; low suppresses all error reporting
- cnt_clr  input  1  synchronous clear of err_cnt
- out_valid  output  1  result of a beat is valid
- word_err  output  LANES  per-lane word parity error for the reported beat
- frame_done  output  1  reported beat closed a frame
- frame_err  output  LANES  per-lane LRC mismatch, valid when frame_done=1
- len_err  output  1  frame exceeded FRAME_MAX beats
- err_cnt  output  CNT_W  saturating count of erroneous beats

Behaviour:
- Reset (RST=1, asynchronous): all outputs 0, LRC accumulators 0, beat counter 0, FSM=IDLE.
- Latency: every output reflects the beat accepted on the previous rising edge (1 cycle). out_valid=1 exactly in the cycle after an in_valid=1 edge, otherwise 0. No backpressure; a beat is accepted whenever in_valid=1.
- Word check, per lane k: raw = (XOR of the lane's DATA_W bits) ^ in_par[k] ^ ODD. word_err[k] = raw & chk_en. This check also applies to the check beat.
- FSM has two states:
  - IDLE: a valid beat with in_last=0 loads the LRC with the lane data, sets beat_cnt=1 and goes to ACCUM.
  - IDLE: a valid beat with in_last=1 is a one-beat frame. frame_done=1 and frame_err[k] = (data != 0) & chk_en. Stay in IDLE.
  - ACCUM: a valid beat with in_last=0 does LRC ^= data and beat_cnt++.
  - ACCUM: a valid beat with in_last=1 sets frame_done=1 and frame_err[k] = (LRC[k] != data[k]) & chk_en. Clear LRC and beat_cnt, go to IDLE.
  - Length limit: if the beat being accepted is beat FRAME_MAX of the frame and in_last=0, assert len_err=1 (gated by chk_en) and frame_done=1, force frame_err=0, clear state and go to IDLE. The next beat then starts a new frame.
- An invalid cycle (in_valid=0) leaves all state unchanged; flags deassert the following cycle.
- err_cnt:
  - Increments by 1 on each accepted beat where any word_err, frame_err or len_err bit is set. Multiple errors in one beat count once.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment: the counter becomes 0 on that edge, and an error on the same beat is dropped.
- chk_en=0: LRC and FSM still track frames so that alignment is kept; only flags and counting are suppressed.
- A reset mid-frame discards the partial frame. The first beat after reset starts a new frame.

Test Plan:
- Defaults: one beat, lane0=0x0001 par0=1, lane1=0x0003 par1=0, in_last=0 -> next cycle out_valid=1, word_err=2'b00, FSM=ACCUM, err_cnt=0.
- Flip par1 on the same beat -> word_err=2'b10, err_cnt=1. With ODD=1 and the original parities -> word_err=2'b11.
- Three-beat frame, lane0 data 0x00F0, 0x0F00, then check 0x0FF0 with in_last=1 -> frame_done=1, frame_err[0]=0. Check word 0x0FF1 instead -> frame_err[0]=1, err_cnt increments by 1.
- Eight beats with in_last=0 (FRAME_MAX=8) -> on the 8th result len_err=1, frame_done=1. The 9th beat with in_last=1 is judged as a one-beat frame.
- err_cnt at 255 with further errors -> stays 255. cnt_clr=1 together with an error beat -> 0.
- chk_en=0 with a corrupt frame -> all flags 0, err_cnt unchanged. chk_en=1 on the next frame -> checking resumes aligned. RST pulsed mid-frame -> outputs 0 immediately, without waiting for a clock edge.
